// File: rtl/board_memory.sv
// 16x16 board store with place/clear FSM for the game controller; rd_state is a zero-latency read.
// Optional single-level undo is compiled in with `define BOARD_UNDO_EN.
module board_memory (
  input  logic       clk,
  input  logic       reset,
  input  logic       place_req,
  input  logic [7:0] place_pos,
  input  logic [1:0] place_chess,
  input  logic       clear_req,
`ifdef BOARD_UNDO_EN
  input  logic       undo_req,
`endif
  input  logic [7:0] rd_addr,
  output logic [1:0] rd_state,
  output logic       place_ack,
  output logic       place_err,
  output logic       check_start,
  output logic [7:0] last_pos,
  output logic [1:0] last_chess,
  output logic [8:0] move_count,
  output logic       board_full,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StClear, StAck} state_e;

  state_e     state_q, state_d;
  logic [1:0] board_q [256];
  logic [7:0] sweep_q, sweep_d;
  logic [8:0] count_q, count_d;
  logic [7:0] last_pos_q, last_pos_d;
  logic [1:0] last_chess_q, last_chess_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       check_q, check_d;
`ifdef BOARD_UNDO_EN
  logic       undo_valid_q, undo_valid_d;
`endif

  logic       wr_en;
  logic [7:0] wr_addr;
  logic [1:0] wr_data;
  logic       place_ok;

  assign rd_state    = board_q[rd_addr];
  assign place_ack   = ack_q;
  assign place_err   = err_q;
  assign check_start = check_q;
  assign last_pos    = last_pos_q;
  assign last_chess  = last_chess_q;
  assign move_count  = count_q;
  assign board_full  = (count_q == 9'd256);
  assign busy        = (state_q != StIdle);

  assign place_ok = ((place_chess == 2'd1) || (place_chess == 2'd2)) &&
                    (board_q[place_pos] == 2'd0) && !board_full;

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    count_d      = count_q;
    last_pos_d   = last_pos_q;
    last_chess_d = last_chess_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    check_d      = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = place_pos;
    wr_data      = place_chess;
`ifdef BOARD_UNDO_EN
    undo_valid_d = undo_valid_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          // A simultaneous place request is dropped silently.
          state_d = StClear;
          sweep_d = 8'd0;
        end
`ifdef BOARD_UNDO_EN
        else if (undo_req) begin
          state_d = StAck;
          if ((count_q != 9'd0) && undo_valid_q) begin
            wr_en        = 1'b1;
            wr_addr      = last_pos_q;
            wr_data      = 2'd0;
            count_d      = count_q - 9'd1;
            undo_valid_d = 1'b0;
            ack_d        = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        else if (place_req) begin
          state_d = StAck;
          if (place_ok) begin
            wr_en        = 1'b1;
            count_d      = count_q + 9'd1;
            last_pos_d   = place_pos;
            last_chess_d = place_chess;
            ack_d        = 1'b1;
            check_d      = 1'b1;
`ifdef BOARD_UNDO_EN
            undo_valid_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      StClear: begin
        wr_en   = 1'b1;
        wr_addr = sweep_q;
        wr_data = 2'd0;
        sweep_d = sweep_q + 8'd1;
        if (sweep_q == 8'hFF) begin
          state_d      = StIdle;
          count_d      = 9'd0;
          last_pos_d   = 8'd0;
          last_chess_d = 2'd0;
`ifdef BOARD_UNDO_EN
          undo_valid_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      sweep_q      <= 8'd0;
      count_q      <= 9'd0;
      last_pos_q   <= 8'd0;
      last_chess_q <= 2'd0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      check_q      <= 1'b0;
`ifdef BOARD_UNDO_EN
      undo_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      count_q      <= count_d;
      last_pos_q   <= last_pos_d;
      last_chess_q <= last_chess_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      check_q      <= check_d;
`ifdef BOARD_UNDO_EN
      undo_valid_q <= undo_valid_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        board_q[i] <= 2'd0;
      end
    end else if (wr_en) begin
      board_q[wr_addr] <= wr_data;
    end
  end

endmodule
